mem_req_arbiter: RTL and testbench
==================================

MEM_REQ_ARBITER -- requirements
Module: mem_req_arbiter

Interface
REQ-001 Parameter: DEPTH, default 4, maximum outstanding (address-accepted, data-pending) requests tracked; power of two.
REQ-002 clk  in  1  system clock; all state updates on the rising edge.
REQ-003 resetn  in  1  one clock; reset is asynchronous and active-low.
REQ-004 inst_req  in  1  / inst_addr  in  32  fetch request from the fetch path (always a 4-byte read).
REQ-005 inst_addr_ok  out  1  / inst_data_ok  out  1  / inst_rdata  out  32  fetch handshake returns.
REQ-006 data_req  in  1  / data_wr  in  1  / data_size  in  2  / data_wstrb  in  4  / data_addr  in  32  / data_wdata  in  32  load/store request.
REQ-007 data_addr_ok  out  1  / data_data_ok  out  1  / data_rdata  out  32  load/store handshake returns.
REQ-008 mem_req  out  1  / mem_wr  out  1  / mem_size  out  2  / mem_wstrb  out  4  / mem_addr  out  32  / mem_wdata  out  32  shared sram-like request.
REQ-009 mem_addr_ok  in  1  / mem_data_ok  in  1  / mem_rdata  in  32  shared-port returns.
REQ-010 inst_io_cnt  out  4  count of outstanding fetch requests (feeds the fetch cancel logic).

Function
REQ-011 Arbiter FSM states: ARB_IDLE, ARB_INST, ARB_DATA; ARB_INST/ARB_DATA = port locked to that owner.
REQ-012 full = (outstanding count == DEPTH), from registered count only; a same-cycle pop does not clear full.
REQ-013 ARB_IDLE: mem_req = (data_req | inst_req) & ~full; owner = data if data_req else inst (fixed priority, data wins).
REQ-014 ARB_IDLE, mem_req & ~mem_addr_ok -> lock state of the chosen owner; mem_req & mem_addr_ok -> stay ARB_IDLE.
REQ-015 Locked state: mem_req = 1, request fields muxed from the owner regardless of the other requester; mem_addr_ok -> ARB_IDLE next cycle.
REQ-016 Inst owner drives mem_wr=0, mem_size=2'b10, mem_wstrb=4'b0000, mem_wdata=0, mem_addr=inst_addr; data owner passes data_* fields through.
REQ-017 mem_addr_ok routed only to the current owner's addr_ok (combinational); the non-owner's addr_ok = 0; both 0 when mem_req = 0.
REQ-018 Handshake (mem_req & mem_addr_ok) pushes owner ID (0 inst, 1 data) into an in-order ID FIFO of DEPTH entries with wrapping pointers.
REQ-019 mem_data_ok pops the FIFO head and asserts exactly that owner's data_ok the same cycle; inst_rdata = data_rdata = mem_rdata.
REQ-020 Simultaneous push and pop: both performed, count unchanged; push while full cannot occur (REQ-012).
REQ-021 mem_data_ok with FIFO empty: ignored, no data_ok asserted, no state change.
REQ-022 inst_io_cnt: +1 on inst handshake, -1 on inst data_ok, unchanged when both in same cycle; never exceeds DEPTH.
REQ-023 Requesters hold req and fields stable until addr_ok; arbiter never withdraws mem_req before mem_addr_ok.
REQ-024 Zero added latency: addr_ok and data_ok combinational from the mem_* inputs; no request/response buffering beyond the ID FIFO.

Reset
REQ-025 resetn low (any time, async): FSM -> ARB_IDLE, FIFO pointers and count -> 0, inst_io_cnt -> 0.
REQ-026 During and right after reset: mem_req=0, inst_addr_ok=data_addr_ok=inst_data_ok=data_data_ok=0; pending requests are dropped, not replayed.
REQ-027 Responses in flight across reset (mem_data_ok after resetn rises, FIFO empty) are discarded per REQ-021.

Verification
REQ-028 inst_req=1 addr 0x1C000000, mem_addr_ok=1 same cycle -> inst_addr_ok=1, inst_io_cnt=1; mem_data_ok next cycle rdata 0x02800000 -> inst_data_ok=1, inst_rdata=0x02800000, inst_io_cnt=0.
REQ-029 inst_req and data_req (load 0x1C001000) same cycle -> mem_addr=0x1C001000, data_addr_ok on accept, inst granted the following cycle.
REQ-030 inst_req in ARB_IDLE, mem_addr_ok held 0 for 3 cycles, data_req rises cycle 2 -> FSM stays ARB_INST, mem_addr stays inst_addr until accept.
REQ-031 Issue 4 accepted requests (inst,data,inst,data) with no data_ok -> mem_req=0 while full; 4 data_ok pulses -> data_ok routed inst,data,inst,data in order.
REQ-032 Full FIFO, mem_data_ok and new inst_req same cycle -> no grant that cycle; grant next cycle; count 4->3->4.
REQ-033 resetn pulsed low mid-locked with 2 outstanding -> all outputs 0, inst_io_cnt=0; subsequent stray mem_data_ok produces no data_ok.

Source files
------------

// File: rtl/mem_req_arbiter.sv
// Two-requester (fetch, load/store) arbiter onto one shared sram-like port.
// Data has fixed priority, the grant holds until the address is accepted, and responses are routed through an in-order ID FIFO.
module mem_req_arbiter #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        resetn,

  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,

  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,

  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,

  output logic [3:0]  inst_io_cnt
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [1:0] ARB_IDLE = 2'd0;
  localparam logic [1:0] ARB_INST = 2'd1;
  localparam logic [1:0] ARB_DATA = 2'd2;

  logic [1:0]       state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [PTR_W-1:0] wptr, rptr;
  logic             id_fifo [DEPTH];
  logic             full, owner_data, push, pop, head;
  logic             inst_push, inst_pop;

  // full comes from the registered count only, so a same-cycle pop never enables a grant.
  assign full = (cnt == CNT_W'(DEPTH));

  always_comb begin
    owner_data = 1'b0;
    mem_req    = 1'b0;
    case (state)
      ARB_INST: begin
        owner_data = 1'b0;
        mem_req    = 1'b1;
      end
      ARB_DATA: begin
        owner_data = 1'b1;
        mem_req    = 1'b1;
      end
      default: begin
        owner_data = data_req;
        mem_req    = (data_req | inst_req) & ~full;
      end
    endcase
    mem_req = mem_req & resetn;
  end

  always_comb begin
    if (owner_data) begin
      mem_wr    = data_wr;
      mem_size  = data_size;
      mem_wstrb = data_wstrb;
      mem_addr  = data_addr;
      mem_wdata = data_wdata;
    end else begin
      mem_wr    = 1'b0;
      mem_size  = 2'b10;
      mem_wstrb = '0;
      mem_addr  = inst_addr;
      mem_wdata = '0;
    end
  end

  assign push         = mem_req & mem_addr_ok;
  assign inst_addr_ok = push & ~owner_data;
  assign data_addr_ok = push &  owner_data;

  assign head         = id_fifo[rptr];
  assign pop          = mem_data_ok & (cnt != '0);
  assign inst_data_ok = pop & ~head;
  assign data_data_ok = pop &  head;
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;

  assign inst_push = inst_addr_ok;
  assign inst_pop  = inst_data_ok;

  always_comb begin
    state_nxt = state;
    case (state)
      ARB_IDLE: if (mem_req && !mem_addr_ok) state_nxt = data_req ? ARB_DATA : ARB_INST;
      ARB_INST,
      ARB_DATA: if (mem_addr_ok) state_nxt = ARB_IDLE;
      default:  state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= ARB_IDLE;
      cnt         <= '0;
      wptr        <= '0;
      rptr        <= '0;
      inst_io_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (push) wptr <= (wptr == PTR_W'(DEPTH - 1)) ? '0 : wptr + 1'b1;
      if (pop)  rptr <= (rptr == PTR_W'(DEPTH - 1)) ? '0 : rptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      case ({inst_push, inst_pop})
        2'b10:   inst_io_cnt <= inst_io_cnt + 1'b1;
        2'b01:   inst_io_cnt <= inst_io_cnt - 1'b1;
        default: inst_io_cnt <= inst_io_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) id_fifo[wptr] <= owner_data;
  end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Self-checking bench for mem_req_arbiter: directed scenarios plus random traffic,
// checked against a queue-based model of grant, lock and response ordering.
module tb_mem_req_arbiter;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req, inst_addr_ok, inst_data_ok;
  logic [31:0] inst_addr, inst_rdata;
  logic        data_req, data_wr, data_addr_ok, data_data_ok;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  inst_io_cnt;

  always #5 clk = ~clk;

  mem_req_arbiter #(.DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
    .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata), .inst_io_cnt(inst_io_cnt)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: outstanding owners in order, current lock owner (-1 none), fetch count.
  bit m_q[$];
  int m_lock = -1;
  int m_icnt = 0;
  bit e_req, e_own, e_pop, e_head;
  bit i_hold = 0, d_hold = 0;

  task automatic check_val(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_lock = -1;
    m_icnt = 0;
    i_hold = 0;
    d_hold = 0;
  endtask

  task automatic model_comb();
    if (m_lock < 0) begin
      e_req = (data_req || inst_req) && (m_q.size() < DEPTH);
      e_own = data_req;
    end else begin
      e_req = 1'b1;
      e_own = (m_lock == 1);
    end
    e_req  = e_req && resetn;
    e_pop  = mem_data_ok && (m_q.size() > 0);
    e_head = (m_q.size() > 0) ? m_q[0] : 1'b0;
  endtask

  task automatic check_all();
    bit acc;
    model_comb();
    acc = e_req && mem_addr_ok;
    check_val("mem_req", 32'(mem_req), 32'(e_req));
    if (e_req) begin
      check_val("mem_addr",  mem_addr, e_own ? data_addr : inst_addr);
      check_val("mem_wr",    32'(mem_wr), e_own ? 32'(data_wr) : 32'd0);
      check_val("mem_size",  32'(mem_size), e_own ? 32'(data_size) : 32'd2);
      check_val("mem_wstrb", 32'(mem_wstrb), e_own ? 32'(data_wstrb) : 32'd0);
      check_val("mem_wdata", mem_wdata, e_own ? data_wdata : 32'd0);
    end
    check_val("inst_addr_ok", 32'(inst_addr_ok), 32'(acc && !e_own));
    check_val("data_addr_ok", 32'(data_addr_ok), 32'(acc && e_own));
    check_val("inst_data_ok", 32'(inst_data_ok), 32'(e_pop && !e_head));
    check_val("data_data_ok", 32'(data_data_ok), 32'(e_pop && e_head));
    check_val("inst_rdata", inst_rdata, mem_rdata);
    check_val("data_rdata", data_rdata, mem_rdata);
    check_val("inst_io_cnt", 32'(inst_io_cnt), 32'(m_icnt));
  endtask

  // Advance one clock, updating the model from the values checked just before the edge.
  task automatic step();
    bit acc;
    check_all();
    acc = e_req && mem_addr_ok;
    @(posedge clk);
    if (e_pop) begin
      void'(m_q.pop_front());
      if (!e_head) m_icnt--;
    end
    if (acc) begin
      m_q.push_back(e_own);
      if (!e_own) m_icnt++;
    end
    if (m_lock < 0 && e_req && !mem_addr_ok) m_lock = e_own ? 1 : 0;
    else if (m_lock >= 0 && mem_addr_ok) m_lock = -1;
    i_hold = inst_req && !(acc && !e_own);
    d_hold = data_req && !(acc && e_own);
  endtask

  task automatic quiet();
    inst_req = 0; data_req = 0; mem_addr_ok = 0; mem_data_ok = 0;
  endtask

  task automatic drain();
    for (int i = 0; i < 2 * DEPTH && m_q.size() > 0; i++) begin
      @(negedge clk); quiet(); mem_data_ok = 1; mem_rdata = $urandom; #1; step();
    end
  endtask

  initial begin
    resetn = 0; inst_req = 0; inst_addr = 0; data_req = 0; data_wr = 0; data_size = 0;
    data_wstrb = 0; data_addr = 0; data_wdata = 0; mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check_val("rst_mem_req", 32'(mem_req), 32'd0);
    check_val("rst_io_cnt", 32'(inst_io_cnt), 32'd0);
    resetn = 1; model_reset();

    // Single fetch round trip.
    @(negedge clk); inst_req = 1; inst_addr = 32'h1C00_0000; mem_addr_ok = 1; #1;
    check_val("r28_aok", 32'(inst_addr_ok), 32'd1);
    step();
    @(negedge clk); quiet(); mem_data_ok = 1; mem_rdata = 32'h0280_0000; #1;
    check_val("r28_cnt1", 32'(inst_io_cnt), 32'd1);
    check_val("r28_dok", 32'(inst_data_ok), 32'd1);
    check_val("r28_rdata", inst_rdata, 32'h0280_0000);
    step();
    @(negedge clk); quiet(); #1;
    check_val("r28_cnt0", 32'(inst_io_cnt), 32'd0);
    step();

    // Simultaneous requests: data wins, fetch follows.
    @(negedge clk); inst_req = 1; inst_addr = 32'h1C00_0004; data_req = 1; data_wr = 0;
    data_size = 2'b10; data_wstrb = 0; data_addr = 32'h1C00_1000; mem_addr_ok = 1; #1;
    check_val("r29_addr", mem_addr, 32'h1C00_1000);
    check_val("r29_daok", 32'(data_addr_ok), 32'd1);
    step();
    @(negedge clk); data_req = 0; #1;
    check_val("r29_iaok", 32'(inst_addr_ok), 32'd1);
    step();
    drain();

    // Fetch locked while the port stalls; a later load must wait.
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk); inst_req = 1; inst_addr = 32'h1C00_0040; mem_addr_ok = (c == 4);
      data_req = (c >= 2); data_addr = 32'h1C00_2000; #1;
      check_val("r30_addr", mem_addr, 32'h1C00_0040);
      step();
    end
    @(negedge clk); inst_req = 0; mem_addr_ok = 1; #1;
    check_val("r30_data", 32'(data_addr_ok), 32'd1);
    step();
    drain();

    // Fill to DEPTH, verify stall, then ordered routing with pop+grant overlap.
    for (int k = 0; k < DEPTH; k++) begin
      @(negedge clk); quiet(); mem_addr_ok = 1;
      if (k % 2 == 0) begin inst_req = 1; inst_addr = 32'h100 + 32'(k); end
      else begin data_req = 1; data_addr = 32'h200 + 32'(k); end
      #1; step();
    end
    @(negedge clk); quiet(); inst_req = 1; data_req = 1; mem_addr_ok = 1; #1;
    check_val("r31_full", 32'(mem_req), 32'd0);
    step();
    @(negedge clk); data_req = 0; mem_data_ok = 1; #1;
    check_val("r32_nogrant", 32'(mem_req), 32'd0);
    check_val("r32_dok", 32'(inst_data_ok), 32'd1);
    step();
    @(negedge clk); mem_data_ok = 0; #1;
    check_val("r32_grant", 32'(inst_addr_ok), 32'd1);
    step();
    for (int k = 0; k < DEPTH; k++) begin
      @(negedge clk); quiet(); mem_data_ok = 1; #1;
      check_val("r31_order", {30'd0, data_data_ok, inst_data_ok}, (k % 2 == 0) ? 32'd2 : 32'd1);
      step();
    end

    // Async reset mid-lock with two outstanding.
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); quiet(); inst_req = 1; mem_addr_ok = 1; #1; step();
    end
    @(negedge clk); quiet(); inst_req = 1; #1; step();
    @(negedge clk); #2; resetn = 0; mem_addr_ok = 1; mem_data_ok = 1; #1;
    check_val("r33_req", 32'(mem_req), 32'd0);
    check_val("r33_aok", {30'd0, inst_addr_ok, data_addr_ok}, 32'd0);
    check_val("r33_dok", {30'd0, inst_data_ok, data_data_ok}, 32'd0);
    check_val("r33_cnt", 32'(inst_io_cnt), 32'd0);
    model_reset();
    @(negedge clk); quiet(); resetn = 1; mem_data_ok = 1; #1;
    check_val("r33_stray", {30'd0, inst_data_ok, data_data_ok}, 32'd0);
    step();

    // Random traffic respecting the requester hold rule.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (!i_hold) begin
        inst_req  = ($urandom_range(0, 99) < 50);
        inst_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (!d_hold) begin
        data_req   = ($urandom_range(0, 99) < 40);
        data_wr    = $urandom_range(0, 1);
        data_size  = 2'($urandom_range(0, 2));
        data_wstrb = 4'($urandom);
        data_addr  = $urandom;
        data_wdata = $urandom;
      end
      mem_addr_ok = ($urandom_range(0, 99) < 55);
      mem_data_ok = ($urandom_range(0, 99) < 45);
      mem_rdata   = $urandom;
      #1; step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
